// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with an optional skid entry, flush, stall
// and a saturating count of cycles in which no beat is offered downstream.
module pipe_stage_elastic #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 16,
    parameter int SKID_EN    = 1,
    parameter int BUB_W      = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy,
    output logic [BUB_W-1:0]      bubble_cnt
);

    localparam logic [BUB_W-1:0] BUB_MAX = {BUB_W{1'b1}};

    logic                  head_valid_q, head_valid_d;
    logic [DATA_WIDTH-1:0] head_data_q,  head_data_d;
    logic [CTRL_WIDTH-1:0] head_ctrl_q,  head_ctrl_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [BUB_W-1:0]      bubble_q,     bubble_d;
    logic                  accept_s, emit_s;

    // Handshake: with a skid entry, in_ready depends only on a flop and stall.
    always_comb begin
        if (SKID_EN != 0) begin
            in_ready = ~skid_valid_q & ~stall;
        end else begin
            in_ready = (~head_valid_q | out_ready) & ~stall;
        end
        out_valid = head_valid_q & ~stall;
        accept_s  = in_valid & in_ready;
        emit_s    = out_valid & out_ready;
    end

    // Next-state for head and skid entries; cleared entries carry zero payload.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_ctrl_d  = head_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            head_valid_d = 1'b0;
            head_data_d  = '0;
            head_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
        end else if (SKID_EN != 0) begin
            if (emit_s) begin
                if (skid_valid_q) begin
                    head_valid_d = 1'b1;
                    head_data_d  = skid_data_q;
                    head_ctrl_d  = skid_ctrl_q;
                    if (accept_s) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                        skid_ctrl_d  = in_ctrl;
                    end else begin
                        skid_valid_d = 1'b0;
                        skid_data_d  = '0;
                        skid_ctrl_d  = '0;
                    end
                end else if (accept_s) begin
                    head_valid_d = 1'b1;
                    head_data_d  = in_data;
                    head_ctrl_d  = in_ctrl;
                end else begin
                    head_valid_d = 1'b0;
                    head_data_d  = '0;
                    head_ctrl_d  = '0;
                end
            end else if (accept_s) begin
                if (!head_valid_q) begin
                    head_valid_d = 1'b1;
                    head_data_d  = in_data;
                    head_ctrl_d  = in_ctrl;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                    skid_ctrl_d  = in_ctrl;
                end
            end else begin
                head_valid_d = head_valid_q;
            end
        end else begin
            if (accept_s) begin
                head_valid_d = 1'b1;
                head_data_d  = in_data;
                head_ctrl_d  = in_ctrl;
            end else if (emit_s) begin
                head_valid_d = 1'b0;
                head_data_d  = '0;
                head_ctrl_d  = '0;
            end else begin
                head_valid_d = head_valid_q;
            end
        end
    end

    // Bubble counter saturates and ignores flush.
    always_comb begin
        if (out_valid || (bubble_q == BUB_MAX)) begin
            bubble_d = bubble_q;
        end else begin
            bubble_d = bubble_q + BUB_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            bubble_q     <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_ctrl_q  <= head_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            bubble_q     <= bubble_d;
        end
    end

    assign out_data   = head_data_q;
    assign out_ctrl   = head_ctrl_q;
    assign occupancy  = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid and a non-skid instance share stimulus;
// a queue-based model per instance is checked every cycle by a monitor.
module tb_pipe_stage_elastic;

    localparam int BUB_MAX = 15;

    logic        clk = 1'b0;
    logic        rst, flush, stall, in_valid, out_ready;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;

    logic        rdy0, ov0, rdy1, ov1;
    logic [63:0] od0, od1;
    logic [15:0] oc0, oc1;
    logic [1:0]  occ0, occ1;
    logic [3:0]  bc0, bc1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [79:0] q0[$];
    logic [79:0] q1[$];
    int bub0 = 0;
    int bub1 = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_WIDTH(64), .CTRL_WIDTH(16), .SKID_EN(1), .BUB_W(4)) dut0 (
        .cpu_clk(clk), .cpu_rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
        .occupancy(occ0), .bubble_cnt(bc0)
    );

    pipe_stage_elastic #(.DATA_WIDTH(64), .CTRL_WIDTH(16), .SKID_EN(0), .BUB_W(4)) dut1 (
        .cpu_clk(clk), .cpu_rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1), .bubble_cnt(bc1)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    task automatic check_one(input int d, input logic rdy, input logic ov,
                             input logic [63:0] od, input logic [15:0] oc,
                             input logic [1:0] occ, input logic [3:0] bc);
        int n;
        int bm;
        logic [79:0] f;
        logic rdy_m, ov_m;
        n  = (d == 0) ? q0.size() : q1.size();
        bm = (d == 0) ? bub0 : bub1;
        f  = '0;
        if (n > 0) f = (d == 0) ? q0[0] : q1[0];
        rdy_m = (d == 0) ? (n < 2 && !stall) : ((n == 0 || out_ready) && !stall);
        ov_m  = (n > 0) && !stall;
        chk($sformatf("dut%0d in_ready", d), {79'd0, rdy}, {79'd0, rdy_m});
        chk($sformatf("dut%0d out_valid", d), {79'd0, ov}, {79'd0, ov_m});
        chk($sformatf("dut%0d occupancy", d), {78'd0, occ}, 80'(n));
        chk($sformatf("dut%0d bubble_cnt", d), {76'd0, bc}, 80'(bm));
        if (ov_m) chk($sformatf("dut%0d head beat", d), {od, oc}, f);
        else if (n == 0) chk($sformatf("dut%0d empty payload", d), {od, oc}, 80'd0);
        if (rst) begin
            if (d == 0) q0.delete(); else q1.delete();
            bm = 0;
        end else begin
            if (!ov_m && bm < BUB_MAX) bm++;
            if (flush) begin
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                if (ov_m && out_ready) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                if (in_valid && rdy_m) begin
                    if (d == 0) q0.push_back({in_data, in_ctrl});
                    else        q1.push_back({in_data, in_ctrl});
                end
            end
        end
        if (d == 0) bub0 = bm; else bub1 = bm;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_one(0, rdy0, ov0, od0, oc0, occ0, bc0);
            check_one(1, rdy1, ov1, od1, oc1, occ1, bc1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] v;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("reset occupancy", {78'd0, occ0}, 80'd0);
        chk("reset out_valid", {79'd0, ov0}, 80'd0);
        chk("reset in_ready", {79'd0, rdy0}, 80'd1);
        chk("reset bubble", {76'd0, bc0}, 80'd0);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            v = 64'(i * 17);
            in_valid = 1'b1; in_data = v; in_ctrl = v[15:0];
            step();
            chk("stream out_valid", {79'd0, ov0}, 80'd1);
            chk("stream out_data", {16'd0, od0}, {16'd0, v});
            chk("stream occupancy", {78'd0, occ0}, 80'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", {78'd0, occ0}, 80'd0);

        // Backpressure fills the skid entry.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA; in_ctrl = 16'hA;
        step();
        chk("bp occ A", {78'd0, occ0}, 80'd1);
        in_data = 64'hB; in_ctrl = 16'hB;
        step();
        chk("bp occ full", {78'd0, occ0}, 80'd2);
        chk("bp in_ready full", {79'd0, rdy0}, 80'd0);
        in_data = 64'hC; in_ctrl = 16'hC;
        step();
        chk("bp occ held", {78'd0, occ0}, 80'd2);
        chk("bp head A", {16'd0, od0}, 80'hA);
        out_ready = 1'b1;
        step();
        chk("bp head B", {16'd0, od0}, 80'hB);
        step();
        chk("bp head C", {16'd0, od0}, 80'hC);
        chk("bp occ C", {78'd0, occ0}, 80'd1);
        in_valid = 1'b0;
        step();
        chk("bp drained", {78'd0, occ0}, 80'd0);

        // Flush with a full stage and an incoming beat.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1; in_ctrl = 16'h1;
        step();
        in_data = 64'h2; in_ctrl = 16'h2;
        step();
        chk("flush pre occ", {78'd0, occ0}, 80'd2);
        in_data = 64'hDEAD; in_ctrl = 16'hBEEF; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush out_valid", {79'd0, ov0}, 80'd0);
        chk("flush out_ctrl", {64'd0, oc0}, 80'd0);
        chk("flush occupancy", {78'd0, occ0}, 80'd0);
        chk("flush in_ready", {79'd0, rdy0}, 80'd1);
        step();
        chk("flush beat dropped", {79'd0, ov0}, 80'd0);

        // Stall holds the head and counts bubbles.
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55; in_ctrl = 16'h55;
        step();
        in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
        #1;
        chk("stall out_valid", {79'd0, ov0}, 80'd0);
        chk("stall in_ready", {79'd0, rdy0}, 80'd0);
        repeat (3) step();
        chk("stall bubble", {76'd0, bc0}, 80'd4);
        chk("stall occupancy", {78'd0, occ0}, 80'd1);
        stall = 1'b0;
        #1;
        chk("unstall out_valid", {79'd0, ov0}, 80'd1);
        chk("unstall out_data", {16'd0, od0}, 80'h55);
        step();
        chk("unstall emitted once", {79'd0, ov0}, 80'd0);
        chk("unstall bubble", {76'd0, bc0}, 80'd4);

        // Bubble saturation and reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("bubble saturated", {76'd0, bc0}, 80'd15);
        step();
        chk("bubble holds", {76'd0, bc0}, 80'd15);
        rst = 1'b1;
        step();
        chk("bubble reset", {76'd0, bc0}, 80'd0);
        rst = 1'b0;

        // Non-skid stage sustains one beat per cycle.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h100; in_ctrl = 16'h100;
        step();
        for (int i = 1; i <= 4; i++) begin
            v = 64'h100 + 64'(i);
            in_data = v; in_ctrl = v[15:0];
            #1;
            chk("noskid in_ready", {79'd0, rdy1}, 80'd1);
            step();
            chk("noskid out_data", {16'd0, od1}, {16'd0, v});
            chk("noskid occupancy", {78'd0, occ1}, 80'd1);
        end
        in_valid = 1'b0;
        step();

        // Randomized traffic, checked by the monitor.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 249) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            in_data   = {$urandom, $urandom};
            in_ctrl   = 16'($urandom);
            step();
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 Parameter DATA_WIDTH, default 64: payload bits, zeroed on flush.
REQ-002 Parameter CTRL_WIDTH, default 16: control bits (reg_write, mem_write, branch, jump fields), zeroed on flush.
REQ-003 Parameter SKID_EN, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-004 Parameter BUB_W, default 8: bubble counter width.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 cpu_clk  in  1  clock; all state updates on rising edge.
REQ-007 cpu_rst  in  1  synchronous active-high reset.
REQ-008 flush  in  1  discard all held beats.
REQ-009 stall  in  1  freeze stage: no accept, no emit, contents held.
REQ-010 in_valid  in  1  upstream beat valid.
REQ-011 in_ready  out  1  stage can accept this cycle.
REQ-012 in_data  in  DATA_WIDTH  upstream payload.
REQ-013 in_ctrl  in  CTRL_WIDTH  upstream control.
REQ-014 out_valid  out  1  beat available downstream.
REQ-015 out_ready  in  1  downstream accepts.
REQ-016 out_data  out  DATA_WIDTH  head payload.
REQ-017 out_ctrl  out  CTRL_WIDTH  head control.
REQ-018 occupancy  out  2  held beats, 0..2 (0..1 when SKID_EN=0).
REQ-019 bubble_cnt  out  BUB_W  saturating count of cycles with out_valid=0.

Function
REQ-020 Accept = in_valid & in_ready; emit = out_valid & out_ready; beats leave in arrival order, none duplicated or lost except by flush.
REQ-021 Latency: beat accepted into an empty stage at edge N appears on out_valid/out_data/out_ctrl after edge N; no combinational in->out data path.
REQ-022 Storage: head entry (drives outputs) plus skid entry when SKID_EN=1; out_valid = head_valid & ~stall.
REQ-023 SKID_EN=1: in_ready = ~skid_valid & ~stall, sourced from a flop plus stall only; no dependence on out_ready.
REQ-024 SKID_EN=1 update: emit & skid_valid -> head<=skid, and accept writes skid else skid clears; emit & ~skid_valid -> head<=input if accept, else head clears; no emit & accept -> input goes to head if empty, else skid.
REQ-025 SKID_EN=0: in_ready = (~head_valid | out_ready) & ~stall; accept loads head; emit without accept clears head_valid.
REQ-026 Simultaneous accept and emit at occupancy 1 keeps occupancy 1 and sustains one beat per cycle.
REQ-027 stall=1: in_ready=0, out_valid=0, all entries held; releasing stall presents the unchanged head the same cycle.
REQ-028 flush=1 at an edge: both entries valid<=0, data and ctrl<=0; any same-cycle incoming beat dropped; priority flush > stall > handshake.
REQ-029 After flush, in_ready=1 next cycle (stall=0); out_valid=0 until a new beat is accepted.
REQ-030 out_data/out_ctrl equal zero whenever head_valid=0.
REQ-031 bubble_cnt increments by 1 each edge with out_valid=0, holds at 2^BUB_W-1, unaffected by flush.
REQ-032 occupancy equals head_valid + skid_valid after every edge.

Reset
REQ-033 cpu_rst=1 at an edge: all entries invalid, out_data=0, out_ctrl=0, out_valid=0, occupancy=0, bubble_cnt=0; in_ready=1 from the following cycle.
REQ-034 Reset mid-transfer discards held beats; reset overrides flush, stall and handshake.

Verification
REQ-035 Stream 0x11,0x22,0x33 with out_ready=1, SKID_EN=1 -> each out one cycle after accept, one beat per cycle, occupancy stays 1.
REQ-036 SKID_EN=1, out_ready=0, offer 0xA,0xB,0xC -> 0xA,0xB held, occupancy=2, in_ready=0, 0xC not accepted; out_ready=1 -> out 0xA,0xB,0xC in order.
REQ-037 Occupancy 2 plus in_valid=1, flush=1 in one edge -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, incoming beat absent from output.
REQ-038 Head 0x55, stall=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, bubble_cnt +3; stall=0 -> 0x55 emitted once.
REQ-039 BUB_W=4, idle 20 cycles after reset -> bubble_cnt=15 and holds; cpu_rst=1 -> 0.
REQ-040 SKID_EN=0, head valid, out_ready=1, in_valid=1 -> in_ready=1 same cycle, throughput one beat per cycle.
